rr_entry_allocator: RTL

- Rotating-priority entry allocator for DEPTH-entry structures (issue-queue slots, ROB-side tag pools).
- Keeps a busy bitmap and a rotating base pointer.
- Each cycle it offers the first free entry at or above the pointer, wrapping to index 0 if needed.
- Sits directly upstream of the structure it allocates for; consumers return entries through a free port.

---
 rtl/alloc_pkg.sv | 17 +
 rtl/rr_entry_allocator_wrap_first_free.sv | 50 +++++
 rtl/rr_entry_allocator.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alloc_pkg.sv
// Shared definitions for the rotating-priority entry allocator.
//
// Contents:
//   ALLOC_DEPTH  default number of allocatable entries (power of two, >= 2)
//   ALLOC_IDX_W  default entry index width
//   alloc_idx_t  entry index type for the default depth
//   alloc_cnt_t  free-entry count type for the default depth (one bit wider,
//                so that it can hold the value ALLOC_DEPTH)
package alloc_pkg;

  localparam int ALLOC_DEPTH = 16;
  localparam int ALLOC_IDX_W = $clog2(ALLOC_DEPTH);

  typedef logic [ALLOC_IDX_W-1:0] alloc_idx_t;
  typedef logic [ALLOC_IDX_W:0]   alloc_cnt_t;

endpackage

// File: rtl/rr_entry_allocator_wrap_first_free.sv
// wrap_first_free: combinational wrap-around first-set search.
//
// The search looks for the lowest set bit of mask at or above base. If there
// is none, it looks for the lowest set bit below base. If mask is all zero,
// idx is 0.
//
// Ports:
//   mask   in   N       candidate bitmap (1 = eligible)
//   base   in   IDX_W   start position of the search
//   idx    out  IDX_W   index of the first eligible bit after wrapping
//   found  out  1       at least one bit of mask is set
module wrap_first_free
  import alloc_pkg::*;
#(
  parameter int N     = ALLOC_DEPTH,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] base,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N-1:0]     hi;
  logic [N-1:0]     lo;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  always_comb begin
    hi = '0;
    lo = '0;
    for (int i = 0; i < N; i++) begin
      if (IDX_W'(i) >= base) hi[i] = mask[i];
      else                   lo[i] = mask[i];
    end

    // The scan runs from the top bit down, so the final assignment gives the
    // lowest set bit.
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hi[i]) hi_idx = IDX_W'(i);
      if (lo[i]) lo_idx = IDX_W'(i);
    end

    idx   = (|hi) ? hi_idx : lo_idx;
    found = |mask;
  end

endmodule

// File: rtl/rr_entry_allocator.sv
// rr_entry_allocator: rotating-priority allocator for DEPTH entries.
//
// The allocator keeps a busy bitmap and a rotating base pointer. Each cycle it
// offers the first free entry at or above the pointer, wrapping around to
// index 0 when needed. A grant happens in the same cycle as the request. After
// a grant, the pointer moves to one past the granted entry. Freed entries
// become visible to the search on the following cycle.
//
// Optional build macro: RR_ALLOC_DOUBLE_FREE_CHECK_EN
//   This macro adds a sticky err_double_free output and a simulation
//   assertion. Both flag a free of an entry that is not busy.
//
// Ports:
//   clock            in   1        system clock
//   reset_n          in   1        synchronous active-low reset
//   alloc_valid      in   1        requester wants one entry this cycle
//   alloc_ready      out  1        a free entry is offered
//   alloc_idx        out  IDX_W    offered entry (valid when alloc_ready=1)
//   free_valid       in   1        release one entry
//   free_idx         in   IDX_W    entry being released
//   flush            in   1        release everything and reset the pointer
//   free_count       out  IDX_W+1  registered number of free entries
//   full             out  1        registered, free_count == 0
//   empty            out  1        registered, free_count == DEPTH
//   err_double_free  out  1        (macro only) sticky double-free flag
module rr_entry_allocator
  import alloc_pkg::*;
#(
  parameter int DEPTH = ALLOC_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             free_valid,
  input  logic [IDX_W-1:0] free_idx,
  input  logic             flush,
  output logic [IDX_W:0]   free_count,
  output logic             full,
  output logic             empty
`ifdef RR_ALLOC_DOUBLE_FREE_CHECK_EN
  ,
  output logic             err_double_free
`endif
);

  localparam int                CNT_W     = IDX_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] busy;
  logic [IDX_W-1:0] ptr;

  logic             any_free;
  logic             fire;
  logic             free_hit;
  logic [DEPTH-1:0] busy_nxt;
  logic [IDX_W-1:0] ptr_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Search stage: the search sees registered state only.
  wrap_first_free #(
    .N     (DEPTH),
    .IDX_W (IDX_W)
  ) u_search (
    .mask  (~busy),
    .base  (ptr),
    .idx   (alloc_idx),
    .found (any_free)
  );

  assign alloc_ready = reset_n & ~flush & any_free;
  assign fire        = alloc_valid & alloc_ready;
  // A free counts only when it targets an entry that is busy. The grant and a
  // real free can never collide, because alloc_idx always points to an entry
  // that is not busy.
  assign free_hit    = free_valid & busy[free_idx];

  always_comb begin
    busy_nxt = busy;
    ptr_nxt  = ptr;
    cnt_nxt  = free_count - CNT_W'(fire) + CNT_W'(free_hit);
    if (free_hit) busy_nxt[free_idx] = 1'b0;
    if (fire) begin
      busy_nxt[alloc_idx] = 1'b1;
      // DEPTH is a power of two, so the natural overflow gives the wrap.
      ptr_nxt = alloc_idx + IDX_W'(1);
    end
    if (flush) begin
      busy_nxt = '0;
      ptr_nxt  = '0;
      cnt_nxt  = DEPTH_CNT;
    end
  end

  // State stage: full and empty are registered from the next-state count.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      busy       <= '0;
      ptr        <= '0;
      free_count <= DEPTH_CNT;
      full       <= 1'b0;
      empty      <= 1'b1;
    end else begin
      busy       <= busy_nxt;
      ptr        <= ptr_nxt;
      free_count <= cnt_nxt;
      full       <= (cnt_nxt == '0);
      empty      <= (cnt_nxt == DEPTH_CNT);
    end
  end

`ifdef RR_ALLOC_DOUBLE_FREE_CHECK_EN
  logic double_free;
  assign double_free = free_valid & ~busy[free_idx] & ~flush;

  always_ff @(posedge clock) begin
    if (!reset_n)         err_double_free <= 1'b0;
    else if (double_free) err_double_free <= 1'b1;
  end

  a_no_double_free : assert property (@(posedge clock) disable iff (!reset_n)
    !double_free);
`endif

endmodule
